// File: rtl/exec_unit_mc_pkg.sv
// Shared types and helpers for the multi-cycle execute stage: opcodes, FSM states,
// the single-cycle ALU and one step of the shift-add / restoring-divide iteration.
package exec_unit_mc_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned ITER  = WIDTH;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLTU = 3'd5,
    OP_MUL  = 3'd6,
    OP_DIVU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_WB   = 2'd2
  } state_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             dz;
  } alu_res_t;

  // Single-cycle ops; DIVU only reaches here when the divisor is zero.
  function automatic alu_res_t alu_f(input op_e op, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b);
    alu_res_t        r;
    logic [WIDTH:0]  sum;
    logic [WIDTH:0]  diff;
    r    = '0;
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    case (op)
      OP_ADD:  begin r.res = sum[WIDTH-1:0];  r.carry = sum[WIDTH];  end
      OP_SUB:  begin r.res = diff[WIDTH-1:0]; r.carry = diff[WIDTH]; end
      OP_AND:  r.res = a & b;
      OP_OR:   r.res = a | b;
      OP_XOR:  r.res = a ^ b;
      OP_SLTU: r.res = WIDTH'(diff[WIDTH]);
      OP_DIVU: begin r.res = '1; r.dz = 1'b1; end
      default: r = '0;
    endcase
    return r;
  endfunction

  // acc = {hi, lo}: MUL keeps {partial product, multiplier}, DIVU keeps {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] iter_step(input logic is_div,
                                                   input logic [2*WIDTH-1:0] acc,
                                                   input logic [WIDTH-1:0] opnd);
    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] full;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic [2*WIDTH-1:0] r;
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    full   = {sum, acc[WIDTH-1:0]};
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    trial  = rem_sh - {1'b0, opnd};
    if (!is_div) begin
      r = full[2*WIDTH:1];
    end else if (!trial[WIDTH]) begin
      r = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      r = {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

endpackage

// File: rtl/exec_unit_mc_mul_div_iter.sv
// Iterative MUL/DIVU engine: one shared accumulator/shift register and an iteration counter.
// The first step is folded into the load so the answer is ready after ITER cycles.
module exec_unit_mc_mul_div_iter
  import exec_unit_mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             hi_nz_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               hi_nz_q, hi_nz_d;

  always_comb begin
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    if (load_i) begin
      is_div_d = is_div_i;
      opnd_d   = is_div_i ? b_i : a_i;
      acc_d    = iter_step(is_div_i, {WIDTH'(0), (is_div_i ? a_i : b_i)},
                           (is_div_i ? b_i : a_i));
      cnt_d    = CNT_W'(ITER - 1);
      done_d   = 1'b0;
    end else if (cnt_q != '0) begin
      acc_d  = iter_step(is_div_q, acc_q, opnd_q);
      cnt_d  = cnt_q - CNT_W'(1);
      done_d = (cnt_q == CNT_W'(1));
    end
    hi_nz_d = |acc_d[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      hi_nz_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      hi_nz_q  <= hi_nz_d;
    end
  end

  assign done_o   = done_q;
  assign result_o = acc_q[WIDTH-1:0];
  assign hi_nz_o  = hi_nz_q;

endmodule

// File: rtl/exec_unit_mc.sv
// Multi-cycle execute stage feeding the register bank write-back port.
// FSM, single-cycle ALU, and registered write-back / status flags.
module exec_unit_mc
  import exec_unit_mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [AW-1:0]    dst,
  output logic             busy,
  output logic [WIDTH-1:0] wd3,
  output logic [AW-1:0]    wa3,
  output logic             we3,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_dz
);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    dst_q, dst_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] wd3_q, wd3_d;
  logic [AW-1:0]    wa3_q, wa3_d;
  logic             we3_q, we3_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_dz_q, flag_dz_d;

  op_e              op_c;
  alu_res_t         alu_c;
  logic             long_op_c;
  logic             load_c;
  logic             iter_done;
  logic             iter_hi_nz;
  logic [WIDTH-1:0] iter_result;

  assign op_c      = op_e'(op);
  assign alu_c     = alu_f(op_c, src_a, src_b);
  assign long_op_c = (op_c == OP_MUL) || ((op_c == OP_DIVU) && (src_b != '0));

  exec_unit_mc_mul_div_iter u_iter (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_c),
    .is_div_i (op_c == OP_DIVU),
    .a_i      (src_a),
    .b_i      (src_b),
    .done_o   (iter_done),
    .result_o (iter_result),
    .hi_nz_o  (iter_hi_nz)
  );

  // Write-back registers are loaded on the edge entering WB so we3 is high during WB.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dst_d     = dst_q;
    busy_d    = busy_q;
    wd3_d     = wd3_q;
    wa3_d     = wa3_q;
    we3_d     = 1'b0;
    flag_z_d  = flag_z_q;
    flag_c_d  = flag_c_q;
    flag_dz_d = flag_dz_q;
    load_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          op_d   = op_c;
          dst_d  = dst;
          if (long_op_c) begin
            load_c  = 1'b1;
            state_d = S_ITER;
          end else begin
            state_d   = S_WB;
            wd3_d     = alu_c.res;
            wa3_d     = dst;
            we3_d     = (dst != '0);
            flag_z_d  = (alu_c.res == '0);
            flag_c_d  = alu_c.carry;
            flag_dz_d = alu_c.dz;
          end
        end
      end
      S_ITER: begin
        if (iter_done) begin
          state_d   = S_WB;
          wd3_d     = iter_result;
          wa3_d     = dst_q;
          we3_d     = (dst_q != '0);
          flag_z_d  = (iter_result == '0);
          flag_c_d  = (op_q == OP_MUL) && iter_hi_nz;
          flag_dz_d = 1'b0;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      op_q      <= OP_ADD;
      dst_q     <= '0;
      busy_q    <= 1'b0;
      wd3_q     <= '0;
      wa3_q     <= '0;
      we3_q     <= 1'b0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_dz_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      busy_q    <= busy_d;
      wd3_q     <= wd3_d;
      wa3_q     <= wa3_d;
      we3_q     <= we3_d;
      flag_z_q  <= flag_z_d;
      flag_c_q  <= flag_c_d;
      flag_dz_q <= flag_dz_d;
    end
  end

  assign busy    = busy_q;
  assign wd3     = wd3_q;
  assign wa3     = wa3_q;
  assign we3     = we3_q;
  assign flag_z  = flag_z_q;
  assign flag_c  = flag_c_q;
  assign flag_dz = flag_dz_q;

endmodule

// File: tb/tb_exec_unit_mc.sv
// Bench for exec_unit_mc: arithmetic reference model compared every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_exec_unit_mc;

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3;
  localparam logic [2:0] XOR_ = 3'd4, SLTU = 3'd5, MUL = 3'd6, DIVU = 3'd7;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [2:0] op = 3'd0;
  logic [7:0] src_a = 8'd0, src_b = 8'd0;
  logic [2:0] dst = 3'd0;
  logic       busy, we3, flag_z, flag_c, flag_dz;
  logic [7:0] wd3;
  logic [2:0] wa3;

  int checks = 0;
  int errors = 0;

  exec_unit_mc dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .dst(dst), .busy(busy), .wd3(wd3), .wa3(wa3), .we3(we3),
    .flag_z(flag_z), .flag_c(flag_c), .flag_dz(flag_dz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: per accepted op, result from plain arithmetic and a fixed latency.
  int  m_res, m_c, m_dz, m_lat, m_dst, m_cnt;
  bit  m_active;
  int  e_busy, e_we3, e_wd3, e_wa3, e_z, e_c, e_dz;

  task automatic model_calc(input int o, input int a, input int b);
    m_c = 0; m_dz = 0; m_lat = 1;
    case (o)
      0: begin m_res = (a + b) % 256; m_c = int'(a + b > 255); end
      1: begin m_res = (a - b + 256) % 256; m_c = int'(a < b); end
      2: m_res = a & b;
      3: m_res = a | b;
      4: m_res = a ^ b;
      5: m_res = int'(a < b);
      6: begin m_res = (a * b) % 256; m_c = int'((a * b) / 256 != 0); m_lat = 9; end
      default: begin
        if (b == 0) begin m_res = 255; m_dz = 1; end
        else begin m_res = a / b; m_lat = 9; end
      end
    endcase
  endtask

  task automatic publish();
    e_wd3 = m_res; e_wa3 = m_dst; e_we3 = int'(m_dst != 0);
    e_z = int'(m_res == 0); e_c = m_c; e_dz = m_dz;
  endtask

  task automatic model_reset();
    m_active = 0; m_cnt = 0;
    e_busy = 0; e_we3 = 0; e_wd3 = 0; e_wa3 = 0; e_z = 0; e_c = 0; e_dz = 0;
  endtask

  initial begin : model
    bit was_idle;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset();
      end else begin
        was_idle = !m_active;
        e_we3 = 0;
        if (m_active) begin
          m_cnt++;
          if (m_cnt == m_lat) begin m_active = 0; e_busy = 0; end
          else if (m_cnt == m_lat - 1) publish();
        end
        if (was_idle && start) begin
          model_calc(int'(op), int'(src_a), int'(src_b));
          m_dst = int'(dst);
          m_active = 1; m_cnt = 0; e_busy = 1;
          if (m_lat == 1) publish();
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      chk("cyc_busy", busy, e_busy);
      chk("cyc_we3", we3, e_we3);
      chk("cyc_wd3", wd3, e_wd3);
      chk("cyc_wa3", wa3, e_wa3);
      chk("cyc_flag_z", flag_z, e_z);
      chk("cyc_flag_c", flag_c, e_c);
      chk("cyc_flag_dz", flag_dz, e_dz);
    end
  end

  // Called at a negedge; returns the cycle of the we3 pulse (0 = none) and busy cycle count.
  task automatic do_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] d, input bit ghost, output int we_cyc,
                       output int busy_cyc);
    start = 1'b1; op = o; src_a = a; src_b = b; dst = d;
    we_cyc = 0; busy_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0; op = ~o; src_a = ~a; src_b = a ^ b ^ 8'h3C; dst = ~d;
      end
      if (ghost && k == 3) start = 1'b1;
      if (ghost && k == 4) start = 1'b0;
      if (we3) we_cyc = k;
      if (busy) busy_cyc++;
      if (!busy) break;
    end
    chk("op_timeout", busy, 0);
  endtask

  logic [2:0] t_op [7] = '{AND_, OR_, MUL, MUL, DIVU, SUB, SLTU};
  logic [7:0] t_a  [7] = '{8'hA5, 8'hA5, 8'hFF, 8'h03, 8'h07, 8'h03, 8'h09};
  logic [7:0] t_b  [7] = '{8'h3C, 8'h3C, 8'hFF, 8'h04, 8'hC8, 8'h05, 8'h03};
  logic [7:0] t_wd [7] = '{8'h24, 8'hBD, 8'h01, 8'h0C, 8'h00, 8'hFE, 8'h00};
  int         t_c  [7] = '{0, 0, 1, 0, 0, 1, 0};
  int         t_z  [7] = '{0, 0, 0, 0, 1, 0, 1};
  int         t_lat[7] = '{1, 1, 9, 9, 9, 1, 1};

  initial begin : stim
    int wc, bc, first_we, second_we, n;
    logic [7:0] wd_first, wd_second;
    logic [2:0] wa_second;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_we3", we3, 0);
    chk("reset_wd3", wd3, 0);
    chk("reset_flags", {flag_z, flag_c, flag_dz}, 0);
    #2 rst = 1'b1;
    @(negedge clk);

    do_op(ADD, 8'hF0, 8'h20, 3'd3, 1'b0, wc, bc);
    chk("add_we_cycle", wc, 1);
    chk("add_busy_cycles", bc, 1);
    chk("add_wd3", wd3, 8'h10);
    chk("add_wa3", wa3, 3'd3);
    chk("add_flags_zc", {flag_z, flag_c}, 2'b01);

    do_op(MUL, 8'h12, 8'h10, 3'd5, 1'b1, wc, bc);
    chk("mul_we_cycle", wc, 9);
    chk("mul_busy_cycles", bc, 9);
    chk("mul_wd3", wd3, 8'h20);
    chk("mul_flag_c", flag_c, 1);

    do_op(DIVU, 8'd200, 8'd7, 3'd6, 1'b0, wc, bc);
    chk("divu_we_cycle", wc, 9);
    chk("divu_wd3", wd3, 8'd28);
    chk("divu_flags", {flag_z, flag_c, flag_dz}, 3'b000);

    do_op(DIVU, 8'd5, 8'd0, 3'd7, 1'b0, wc, bc);
    chk("div0_we_cycle", wc, 1);
    chk("div0_wd3", wd3, 8'hFF);
    chk("div0_flag_dz", flag_dz, 1);

    // Reset asserted in the middle of a multiply
    start = 1'b1; op = MUL; src_a = 8'h12; src_b = 8'h10; dst = 3'd4;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_mul_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_busy", busy, 0);
    chk("rst_async_we3", we3, 0);
    chk("rst_async_wd3", wd3, 0);
    chk("rst_async_flags", {flag_z, flag_c, flag_dz}, 0);
    @(negedge clk);
    #2 rst = 1'b1;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (we3 || busy) n++;
    end
    chk("no_write_after_rst", n, 0);

    do_op(SUB, 8'd5, 8'd5, 3'd0, 1'b0, wc, bc);
    chk("sub_r0_we_cycle", wc, 0);
    chk("sub_r0_busy_cycles", bc, 1);
    chk("sub_r0_flag_z", flag_z, 1);
    chk("sub_r0_wd3", wd3, 8'h00);

    for (int i = 0; i < 7; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 3'd1, 1'b0, wc, bc);
      chk("tbl_we_cycle", wc, t_lat[i]);
      chk("tbl_wd3", wd3, t_wd[i]);
      chk("tbl_flag_c", flag_c, t_c[i]);
      chk("tbl_flag_z", flag_z, t_z[i]);
    end

    // Back-to-back with start held high
    first_we = 0; second_we = 0; wd_first = 8'h00; wd_second = 8'h00; wa_second = 3'd0;
    start = 1'b1; op = XOR_; src_a = 8'h5A; src_b = 8'h0F; dst = 3'd1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin op = SLTU; src_a = 8'd3; src_b = 8'd9; dst = 3'd2; end
      if (k == 3) start = 1'b0;
      if (we3 && first_we == 0) begin first_we = k; wd_first = wd3; end
      else if (we3) begin second_we = k; wd_second = wd3; wa_second = wa3; end
    end
    chk("b2b_first_cycle", first_we, 1);
    chk("b2b_first_wd3", wd_first, 8'h55);
    chk("b2b_spacing", second_we - first_we, 2);
    chk("b2b_second_wd3", wd_second, 8'h01);
    chk("b2b_second_wa3", wa_second, 3'd2);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
